// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: transfer encodings, FSM
// states, slave address windows and the largest accepted transfer size.
// Optional feature macro: APB_PSLVERR_EN (adds the ERR state).
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

`ifdef APB_PSLVERR_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR    = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;
`endif

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] HSIZE_MAX = 3'd2;

  // True for transfer types that carry a real transfer.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: range check plus one-hot slave select.
module apb_addr_decode
  import ahb_apb_pkg::*;
(
  input  logic [31:0] haddr,
  output logic        in_range,
  output logic [2:0]  sel
);

  // Map the address onto one of the three slave windows.
  always_comb begin
    sel = '0;
    if (haddr >= SLV0_BASE && haddr <= SLV0_LIMIT)
      sel = 3'b001;
    else if (haddr >= SLV1_BASE && haddr <= SLV1_LIMIT)
      sel = 3'b010;
    else if (haddr >= SLV2_BASE && haddr <= SLV2_LIMIT)
      sel = 3'b100;
    in_range = |sel;
  end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: accepts single AHB transfers to three APB
// slave windows and sequences them through the APB setup/access phases.
// Optional feature macro: APB_PSLVERR_EN (Pslverr input, ERROR response).
module apb_bridge_ctrl
  import ahb_apb_pkg::*;
(
  input  logic        clk,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic        Hreadyin,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata,
  input  logic [31:0] Prdata,
`ifdef APB_PSLVERR_EN
  input  logic        Pslverr,
`endif
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  state_e      state, state_nxt;
  logic [2:0]  sel_q;
  logic [2:0]  dec_sel;
  logic        in_range;
  logic        accept;
  state_e      exit_state;

  apb_addr_decode u_decode (
    .haddr    (Haddr),
    .in_range (in_range),
    .sel      (dec_sel)
  );

  assign Hrdata = Prdata;

  // Transfer acceptance; Hreadyout already encodes "bridge can take one".
  always_comb begin
    accept = Hresetn && Hreadyin && Hreadyout && htrans_active(Htrans) &&
             (Hsize <= HSIZE_MAX) && in_range;
  end

  // State-driven AHB/APB handshake outputs.
  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 1'b0;
    Pselx     = '0;
    Penable   = 1'b0;
    case (state)
      ST_IDLE:  ;
      ST_WWAIT: Hreadyout = 1'b0;
      ST_SETUP: begin
        Hreadyout = 1'b0;
        Pselx     = sel_q;
      end
      ST_ACCESS: begin
        Pselx   = sel_q;
        Penable = 1'b1;
`ifdef APB_PSLVERR_EN
        if (Pslverr) begin
          Hreadyout = 1'b0;
          Hresp     = 1'b1;
        end
`endif
      end
`ifdef APB_PSLVERR_EN
      ST_ERR:   Hresp = 1'b1;
`endif
      default:  ;
    endcase
  end

  // Next-state logic; ACCESS and ERR share the same exit decision.
  always_comb begin
    exit_state = ST_IDLE;
    if (accept)
      exit_state = Hwrite ? ST_WWAIT : ST_SETUP;
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = exit_state;
      ST_WWAIT:  state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        state_nxt = exit_state;
`ifdef APB_PSLVERR_EN
        if (Pslverr) state_nxt = ST_ERR;
`endif
      end
`ifdef APB_PSLVERR_EN
      ST_ERR:    state_nxt = exit_state;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered APB address/control/data.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        sel_q  <= dec_sel;
      end
      if (state == ST_WWAIT)
        Pwdata <= Hwdata;
    end
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Self-checking bench for apb_bridge_ctrl: transaction-level model plus
// directed vectors with literal expectations.
module tb_apb_bridge_ctrl;

  logic        clk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic        Hreadyin;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Prdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
`ifdef APB_PSLVERR_EN
  logic        Pslverr;
`endif

  int total = 0;
  int bad   = 0;

  apb_bridge_ctrl dut (
    .clk       (clk),
    .Hresetn   (Hresetn),
    .Htrans    (Htrans),
    .Hsize     (Hsize),
    .Hreadyin  (Hreadyin),
    .Hwrite    (Hwrite),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Prdata    (Prdata),
`ifdef APB_PSLVERR_EN
    .Pslverr   (Pslverr),
`endif
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a pending transfer is described only by its age in
  // cycles since acceptance; reads last 2 cycles, writes 3, the APB access
  // phase is the last cycle and setup the one before it.
  logic        model_on = 1'b0;
  logic        m_busy   = 1'b0;
  int          m_age    = 0;
  logic        m_wr     = 1'b0;
  logic [2:0]  m_sel    = '0;
  logic [31:0] m_paddr  = '0;
  logic [31:0] m_pwdata = '0;
  logic        m_pwrite = 1'b0;

  function automatic int m_len();
    return m_wr ? 3 : 2;
  endfunction

  function automatic logic m_ready();
    return !m_busy || (m_age == m_len() - 1);
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic rdy;
    rdy = m_ready();
    if (!Hresetn) begin
      m_busy = 1'b0; m_age = 0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    end else begin
      if (m_busy && m_wr && m_age == 0) m_pwdata = Hwdata;
      acc = Hreadyin && rdy && (Htrans >= 2'd2) && (Hsize <= 3'd2) &&
            (Haddr >= 32'h8000_0000) && (Haddr < 32'h8C00_0000);
      if (acc) begin
        m_busy = 1'b1; m_age = 0; m_wr = Hwrite;
        m_paddr = Haddr; m_pwrite = Hwrite;
        m_sel = 3'b001 << ((Haddr - 32'h8000_0000) >> 26);
      end else if (m_busy) begin
        if (m_age == m_len() - 1) m_busy = 1'b0;
        else m_age++;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic       e_pen;
    logic [2:0] e_sel;
    if (model_on) begin
      e_pen = m_busy && (m_age == m_len() - 1);
      e_sel = (m_busy && m_age >= m_len() - 2) ? m_sel : 3'b000;
      chk("m_hreadyout", {31'd0, Hreadyout}, {31'd0, m_ready()});
      chk("m_hresp",     {31'd0, Hresp},     32'd0);
      chk("m_pselx",     {29'd0, Pselx},     {29'd0, e_sel});
      chk("m_penable",   {31'd0, Penable},   {31'd0, e_pen});
      chk("m_paddr",     Paddr,              m_paddr);
      chk("m_pwrite",    {31'd0, Pwrite},    {31'd0, m_pwrite});
      chk("m_pwdata",    Pwdata,             m_pwdata);
      if (e_pen) chk("m_hrdata", Hrdata, Prdata);
    end
  end

  task automatic step(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] sz, input logic rdy);
    Htrans = tr; Hwrite = wr; Haddr = a; Hwdata = wd; Hsize = sz; Hreadyin = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] wd);
    step(2'd0, 1'b0, 32'h0, wd, 3'd2, 1'b1);
  endtask

  initial begin
    Hresetn = 1'b0; Prdata = 32'h0;
`ifdef APB_PSLVERR_EN
    Pslverr = 1'b0;
`endif
    idle(0); idle(0);
    chk("rst_hreadyout", {31'd0, Hreadyout}, 32'd1);
    chk("rst_pselx",     {29'd0, Pselx},     32'd0);
    chk("rst_paddr",     Paddr,              32'd0);
    chk("rst_hresp",     {31'd0, Hresp},     32'd0);
    model_on = 1'b1;
    Hresetn = 1'b1;
    idle(0);

    // Read to slave 1.
    Prdata = 32'hDEAD_BEEF;
    step(2'd2, 1'b0, 32'h8400_0010, 0, 3'd2, 1'b1);
    chk("rd_setup_pselx",   {29'd0, Pselx},     32'b010);
    chk("rd_setup_penable", {31'd0, Penable},   32'd0);
    chk("rd_setup_ready",   {31'd0, Hreadyout}, 32'd0);
    idle(0);
    chk("rd_acc_penable",   {31'd0, Penable},   32'd1);
    chk("rd_acc_ready",     {31'd0, Hreadyout}, 32'd1);
    chk("rd_acc_hrdata",    Hrdata,             32'hDEAD_BEEF);
    idle(0);

    // Write to slave 2.
    step(2'd2, 1'b1, 32'h8800_0004, 0, 3'd2, 1'b1);
    chk("wr_wwait_ready",   {31'd0, Hreadyout}, 32'd0);
    idle(32'h1234_5678);
    chk("wr_setup_ready",   {31'd0, Hreadyout}, 32'd0);
    chk("wr_setup_pselx",   {29'd0, Pselx},     32'b100);
    chk("wr_setup_paddr",   Paddr,              32'h8800_0004);
    chk("wr_setup_pwdata",  Pwdata,             32'h1234_5678);
    chk("wr_setup_pwrite",  {31'd0, Pwrite},    32'd1);
    idle(0);
    chk("wr_acc_ready",     {31'd0, Hreadyout}, 32'd1);
    chk("wr_acc_penable",   {31'd0, Penable},   32'd1);
    chk("wr_acc_pselx",     {29'd0, Pselx},     32'b100);
    chk("wr_acc_pwdata",    Pwdata,             32'h1234_5678);
    idle(0);

    // Back-to-back reads, then a write accepted straight from ACCESS.
    Prdata = 32'h0BAD_F00D;
    step(2'd2, 1'b0, 32'h8000_0000, 0, 3'd2, 1'b1);
    idle(0);
    chk("b2b_acc1_penable", {31'd0, Penable}, 32'd1);
    step(2'd3, 1'b0, 32'h8000_0004, 0, 3'd2, 1'b1);
    chk("b2b_setup2_paddr",   Paddr,            32'h8000_0004);
    chk("b2b_setup2_penable", {31'd0, Penable}, 32'd0);
    chk("b2b_setup2_pselx",   {29'd0, Pselx},   32'b001);
    idle(0);
    step(2'd2, 1'b1, 32'h8000_0100, 0, 3'd1, 1'b1);
    chk("b2b_wwait_ready", {31'd0, Hreadyout}, 32'd0);
    chk("b2b_wwait_pselx", {29'd0, Pselx},     32'd0);
    idle(32'hA5A5_5A5A);
    chk("b2b_wr_pwdata", Pwdata, 32'hA5A5_5A5A);
    idle(0); idle(0);

    // Ignored transfers.
    step(2'd2, 1'b0, 32'h9000_0000, 0, 3'd2, 1'b1);
    chk("ign_range_pselx", {29'd0, Pselx},     32'd0);
    chk("ign_range_ready", {31'd0, Hreadyout}, 32'd1);
    step(2'd1, 1'b0, 32'h8000_0000, 0, 3'd2, 1'b1);
    chk("ign_busy_pselx",  {29'd0, Pselx},     32'd0);
    chk("ign_busy_hresp",  {31'd0, Hresp},     32'd0);
    step(2'd2, 1'b0, 32'h8000_0000, 0, 3'd3, 1'b1);
    chk("ign_size_ready",  {31'd0, Hreadyout}, 32'd1);
    step(2'd2, 1'b0, 32'h8C00_0000, 0, 3'd2, 1'b1);
    chk("ign_limit_pselx", {29'd0, Pselx},     32'd0);
    step(2'd2, 1'b0, 32'h8000_0040, 0, 3'd2, 1'b0);
    chk("ign_nrdy_pselx",  {29'd0, Pselx},     32'd0);
    step(2'd2, 1'b0, 32'h8BFF_FFFC, 0, 3'd0, 1'b1);
    chk("edge_hi_pselx",   {29'd0, Pselx},     32'b100);
    idle(0); idle(0);

    // Reset in SETUP, and a transfer presented during reset is dropped.
    step(2'd2, 1'b0, 32'h8400_0000, 0, 3'd2, 1'b1);
    Hresetn = 1'b0;
    step(2'd2, 1'b0, 32'h8400_0008, 0, 3'd2, 1'b1);
    chk("mrst_pselx",   {29'd0, Pselx},     32'd0);
    chk("mrst_penable", {31'd0, Penable},   32'd0);
    chk("mrst_paddr",   Paddr,              32'd0);
    chk("mrst_ready",   {31'd0, Hreadyout}, 32'd1);
    Hresetn = 1'b1;
    idle(0);
    chk("mrst_noacc_pselx", {29'd0, Pselx}, 32'd0);
    idle(0);

`ifdef APB_PSLVERR_EN
    model_on = 1'b0;
    step(2'd2, 1'b0, 32'h8000_0020, 0, 3'd2, 1'b1);
    idle(0);
    Pslverr = 1'b1;
    #1;
    chk("err_acc_ready", {31'd0, Hreadyout}, 32'd0);
    chk("err_acc_hresp", {31'd0, Hresp},     32'd1);
    step(2'd2, 1'b0, 32'h8400_0000, 0, 3'd2, 1'b1);
    Pslverr = 1'b0;
    chk("err_err_ready", {31'd0, Hreadyout}, 32'd1);
    chk("err_err_hresp", {31'd0, Hresp},     32'd1);
    chk("err_err_pselx", {29'd0, Pselx},     32'd0);
    idle(0);
    chk("err_idle_hresp", {31'd0, Hresp}, 32'd0);
    Hresetn = 1'b0;
    idle(0);
    Hresetn = 1'b1;
    model_on = 1'b1;
    idle(0);
`endif

    idle(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
